// File: rtl/i2c_master_ctrl_if.sv
// Command/status bundle between the system side and the single-byte I2C master.
// The system drives a command strobe; the controller returns ready, done, ack_err and rdata.
interface i2c_master_ctrl_if;
    logic       start;
    logic       rw_bit;
    logic [6:0] slv_addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;

    modport master (
        output start, rw_bit, slv_addr, wdata,
        input  ready, done, ack_err, rdata
    );

    modport slave (
        input  start, rw_bit, slv_addr, wdata,
        output ready, done, ack_err, rdata
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, STOP.
// Optional macro I2C_MST_SDA_SYNC_EN adds a 2-flop synchronizer on the SDA input.
module i2c_master_ctrl #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int I2C_FREQ_HZ = 100_000,
    parameter int QDIV        = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ)
) (
    input  logic             clk,
    input  logic             reset,
    i2c_master_ctrl_if.slave cmd,
    output logic             i2c_scl,
    inout  wire              i2c_sda,
    output logic [3:0]       mst_state
);

    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        START      = 4'd1,
        ADDR       = 4'd2,
        ADDR_ACK   = 4'd3,
        WDATA      = 4'd4,
        WDATA_ACK  = 4'd5,
        RDATA      = 4'd6,
        RDATA_NACK = 4'd7,
        STOP       = 4'd8
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [QW-1:0]   q_cnt;
    logic [1:0]      qtr;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic [7:0]      wdata_q;
    logic            rw_q;
    logic            sda_low;
    logic            sda_in;
    logic            accept;
    logic            qtick;
    logic            q2_end;
    logic            bit_end;
    logic            last_bit;
    logic            scl_pulse;

`ifdef I2C_MST_SDA_SYNC_EN
    logic [1:0] sda_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], i2c_sda};
        end
    end

    assign sda_in = sda_sync[1];
`else
    assign sda_in = i2c_sda;
`endif

    assign cmd.ready = (state == IDLE);
    assign accept    = cmd.start && (state == IDLE);
    assign qtick     = (q_cnt == QLAST);
    assign q2_end    = qtick && (qtr == 2'd2);
    assign bit_end   = qtick && (qtr == 2'd3);
    assign last_bit  = (bit_cnt == 3'd7);
    assign scl_pulse = qtr[0] ^ qtr[1];
    assign mst_state = state;

    // Open-drain: only ever pull low, otherwise release the line.
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        i2c_scl  = 1'b1;
        sda_low  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = START;
            end
            START: begin
                sda_low = qtr[1];
                i2c_scl = (qtr != 2'd3);
                if (bit_end) state_nx = ADDR;
            end
            ADDR: begin
                i2c_scl = scl_pulse;
                sda_low = !shift_reg[7];
                if (bit_end && last_bit) state_nx = ADDR_ACK;
            end
            ADDR_ACK: begin
                i2c_scl = scl_pulse;
                if (bit_end) begin
                    if (cmd.ack_err) state_nx = STOP;
                    else if (rw_q)   state_nx = RDATA;
                    else             state_nx = WDATA;
                end
            end
            WDATA: begin
                i2c_scl = scl_pulse;
                sda_low = !shift_reg[7];
                if (bit_end && last_bit) state_nx = WDATA_ACK;
            end
            WDATA_ACK: begin
                i2c_scl = scl_pulse;
                if (bit_end) state_nx = STOP;
            end
            RDATA: begin
                i2c_scl = scl_pulse;
                if (bit_end && last_bit) state_nx = RDATA_NACK;
            end
            RDATA_NACK: begin
                i2c_scl = scl_pulse;
                if (bit_end) state_nx = STOP;
            end
            STOP: begin
                i2c_scl = (qtr != 2'd0);
                sda_low = !qtr[1];
                if (bit_end) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_cnt       <= '0;
            qtr         <= 2'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            wdata_q     <= 8'd0;
            rw_q        <= 1'b0;
            cmd.done    <= 1'b0;
            cmd.ack_err <= 1'b0;
            cmd.rdata   <= 8'd0;
        end else begin
            cmd.done <= 1'b0;
            if (accept) begin
                q_cnt       <= '0;
                qtr         <= 2'd0;
                bit_cnt     <= 3'd0;
                shift_reg   <= {cmd.slv_addr, cmd.rw_bit};
                wdata_q     <= cmd.wdata;
                rw_q        <= cmd.rw_bit;
                cmd.ack_err <= 1'b0;
            end else if (state != IDLE) begin
                q_cnt <= qtick ? '0 : q_cnt + 1'b1;
                if (qtick) qtr <= qtr + 2'd1;
                case (state)
                    ADDR, WDATA: begin
                        if (bit_end) begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            bit_cnt   <= last_bit ? 3'd0 : bit_cnt + 3'd1;
                        end
                    end
                    ADDR_ACK: begin
                        if (q2_end && sda_in) cmd.ack_err <= 1'b1;
                        if (bit_end) shift_reg <= wdata_q;
                    end
                    WDATA_ACK: begin
                        if (q2_end && sda_in) cmd.ack_err <= 1'b1;
                    end
                    RDATA: begin
                        if (q2_end) shift_reg <= {shift_reg[6:0], sda_in};
                        // Bit 7 was shifted in at q2, so the byte is whole by q3.
                        if (bit_end) begin
                            bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
                            if (last_bit) cmd.rdata <= shift_reg;
                        end
                    end
                    STOP: begin
                        if (bit_end) cmd.done <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench: behavioural LED slave at 7'h02 plus a transaction-level model.
// Runs with QDIV=4 so both SDA-sync builds are exercised at the tightest timing.
module tb_i2c_master_ctrl;

    localparam int QD   = 4;
    localparam int BITC = 4 * QD;
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_START = 4'd1;
    localparam logic [3:0] S_ADDR  = 4'd2;
    localparam logic [3:0] S_WDATA = 4'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i2c_scl;
    logic [3:0] mst_state;
    wire        i2c_sda;
    logic       sl_drive = 1'b0;

    i2c_master_ctrl_if bus ();

    pullup (i2c_sda);
    assign i2c_sda = sl_drive ? 1'b0 : 1'bz;

    i2c_master_ctrl #(
        .CLK_FREQ_HZ (1_600_000),
        .I2C_FREQ_HZ (100_000),
        .QDIV        (QD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (bus),
        .i2c_scl   (i2c_scl),
        .i2c_sda   (i2c_sda),
        .mst_state (mst_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    // Behavioural LED slave, polled on the falling clk edge.
    bit         bits[$];
    int         nrise = 0;
    int         nstart = 0;
    int         nstop = 0;
    logic       active = 1'b0;
    logic       sel = 1'b0;
    logic       srw = 1'b0;
    logic [7:0] sh8 = 8'd0;
    logic [7:0] rx = 8'd0;
    logic [7:0] tx = 8'd0;
    logic [7:0] led = 8'd0;

    initial begin
        logic p_scl;
        logic p_sda;
        logic scl;
        logic sda;
        p_scl = 1'b1;
        p_sda = 1'b1;
        forever begin
            @(negedge clk);
            scl = i2c_scl;
            sda = i2c_sda;
            if (p_scl && scl && p_sda && !sda) begin
                active = 1'b1;
                nrise = 0;
                bits.delete();
                sl_drive = 1'b0;
                nstart++;
            end else if (p_scl && scl && !p_sda && sda) begin
                active = 1'b0;
                nstop++;
            end else if (!p_scl && scl && active) begin
                nrise++;
                bits.push_back(sda);
                if (nrise <= 8) sh8 = {sh8[6:0], sda};
                if (nrise == 8) begin
                    sel = (sh8[7:1] == 7'h02);
                    srw = sh8[0];
                    tx = led;
                end
                if (nrise >= 10 && nrise <= 17) rx = {rx[6:0], sda};
                if (nrise == 17 && sel && !srw) led = rx;
            end else if (p_scl && !scl && active) begin
                sl_drive = 1'b0;
                if (nrise == 8 && sel) sl_drive = 1'b1;
                if (sel && srw && nrise >= 9 && nrise <= 16) sl_drive = !tx[16 - nrise];
                if (sel && !srw && nrise == 17) sl_drive = 1'b1;
            end
            p_scl = scl;
            p_sda = i2c_sda;
        end
    end

    // Transaction-level reference state.
    logic [7:0] ref_led = 8'd0;
    logic [7:0] ref_rdata = 8'd0;

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.slv_addr = a;
        bus.rw_bit = r;
        bus.wdata = d;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        bit got = 0;
        while (n < 600 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) got = 1;
        end
        lat = cyc - t0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout waited %0d cycles", n);
            lat = -1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.rw_bit = 1'b0;
        bus.slv_addr = 7'd0;
        bus.wdata = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.ready); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        checks++;
        if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got %b exp 0", bus.ack_err); end
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", bus.rdata); end
        checks++;
        if (i2c_scl !== 1'b1) begin errors++; $display("FAIL rst_scl got %b exp 1", i2c_scl); end
        checks++;
        if (i2c_sda !== 1'b1) begin errors++; $display("FAIL rst_sda got %b exp 1", i2c_sda); end
        checks++;
        if (mst_state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", mst_state, S_IDLE); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write;
        int lat;
        int s0;
        int p0;
        int dc0;
        logic [17:0] exp_seq;
        logic [17:0] got_seq;
        exp_seq = {7'h02, 1'b0, 1'b0, 8'hA5, 1'b0};
        got_seq = '0;
        s0 = nstart;
        p0 = nstop;
        dc0 = done_cnt;
        issue(7'h02, 1'b0, 8'hA5);
        wait_done(lat);
        repeat (4) @(posedge clk);
        #1;
        ref_led = 8'hA5;
        if (bits.size() >= 18) begin
            for (int i = 0; i < 18; i++) got_seq = {got_seq[16:0], bits[i]};
        end
        checks++;
        if (got_seq !== exp_seq) begin errors++; $display("FAIL wr_seq got %b exp %b", got_seq, exp_seq); end
        checks++;
        if (nrise !== 19) begin errors++; $display("FAIL wr_rises got %0d exp 19", nrise); end
        checks++;
        if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL wr_ack_err got %b exp 0", bus.ack_err); end
        checks++;
        if (led !== ref_led) begin errors++; $display("FAIL wr_led got %h exp %h", led, ref_led); end
        checks++;
        if (done_cnt - dc0 !== 1) begin errors++; $display("FAIL wr_done_pulses got %0d exp 1", done_cnt - dc0); end
        checks++;
        if (lat < 20 * BITC - 1 || lat > 20 * BITC + 1) begin
            errors++; $display("FAIL wr_latency got %0d exp %0d", lat, 20 * BITC);
        end
        checks++;
        if (nstart - s0 !== 1 || nstop - p0 !== 1) begin
            errors++; $display("FAIL wr_start_stop got %0d/%0d exp 1/1", nstart - s0, nstop - p0);
        end
    endtask

    task automatic test_addr_nack;
        int lat;
        issue(7'h05, 1'b0, 8'h77);
        wait_done(lat);
        #1;
        checks++;
        if (bus.ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err got %b exp 1", bus.ack_err); end
        checks++;
        if (nrise + 1 !== 11) begin errors++; $display("FAIL nack_bits got %0d exp 11", nrise + 1); end
        checks++;
        if (lat < 11 * BITC - 1 || lat > 11 * BITC + 1) begin
            errors++; $display("FAIL nack_latency got %0d exp %0d", lat, 11 * BITC);
        end
        checks++;
        if (led !== ref_led) begin errors++; $display("FAIL nack_led got %h exp %h", led, ref_led); end
    endtask

    task automatic test_read(input logic [7:0] val);
        int lat;
        issue(7'h02, 1'b0, val);
        wait_done(lat);
        ref_led = val;
        issue(7'h02, 1'b1, 8'h00);
        wait_done(lat);
        #1;
        ref_rdata = ref_led;
        checks++;
        if (bus.rdata !== ref_rdata) begin errors++; $display("FAIL rd_data got %h exp %h", bus.rdata, ref_rdata); end
        checks++;
        if (bus.ack_err !== 1'b0) begin errors++; $display("FAIL rd_ack_err got %b exp 0", bus.ack_err); end
        checks++;
        if (bits.size() < 18 || bits[17] !== 1'b1) begin
            errors++; $display("FAIL rd_master_nack got size %0d exp released bit 18", bits.size());
        end
    endtask

    task automatic test_busy;
        int lat;
        int n = 0;
        issue(7'h02, 1'b0, 8'h5A);
        while (mst_state !== S_ADDR && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        bus.slv_addr = 7'h05;
        bus.rw_bit = 1'b1;
        bus.wdata = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.ready !== 1'b0 || mst_state !== S_ADDR) begin
            errors++; $display("FAIL busy_ignored got ready %b state %0d exp 0/%0d", bus.ready, mst_state, S_ADDR);
        end
        wait_done(lat);
        #1;
        ref_led = 8'h5A;
        checks++;
        if (led !== ref_led || bus.ack_err !== 1'b0) begin
            errors++; $display("FAIL busy_complete got led %h ack_err %b exp %h/0", led, bus.ack_err, ref_led);
        end
        checks++;
        if (lat < 20 * BITC - 1 || lat > 20 * BITC + 1) begin
            errors++; $display("FAIL busy_latency got %0d exp %0d", lat, 20 * BITC);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int n = 0;
        issue(7'h02, 1'b0, 8'hC3);
        while (mst_state !== S_WDATA && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3 * BITC + 6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (i2c_scl !== 1'b1 || i2c_sda !== 1'b1) begin
            errors++; $display("FAIL midrst_bus got scl %b sda %b exp 1/1", i2c_scl, i2c_sda);
        end
        checks++;
        if (bus.ready !== 1'b1 || mst_state !== S_IDLE) begin
            errors++; $display("FAIL midrst_idle got ready %b state %0d exp 1/0", bus.ready, mst_state);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led !== ref_led) begin errors++; $display("FAIL midrst_led got %h exp %h", led, ref_led); end
        issue(7'h02, 1'b0, 8'h99);
        wait_done(lat);
        #1;
        ref_led = 8'h99;
        checks++;
        if (led !== ref_led || bus.ack_err !== 1'b0) begin
            errors++; $display("FAIL midrst_next got led %h ack_err %b exp %h/0", led, bus.ack_err, ref_led);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [6:0] a;
        logic r;
        logic [7:0] d;
        bit hit;
        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 2) != 0) ? 7'h02 : 7'($urandom);
            r = 1'($urandom);
            d = 8'($urandom);
            hit = (a == 7'h02);
            issue(a, r, d);
            wait_done(lat);
            #1;
            if (hit && !r) ref_led = d;
            if (hit && r) ref_rdata = ref_led;
            checks++;
            if (bus.ack_err !== !hit) begin
                errors++; $display("FAIL rnd_ack_err[%0d] a=%h got %b exp %b", i, a, bus.ack_err, !hit);
            end
            checks++;
            if (bus.rdata !== ref_rdata) begin
                errors++; $display("FAIL rnd_rdata[%0d] got %h exp %h", i, bus.rdata, ref_rdata);
            end
            checks++;
            if (led !== ref_led) begin
                errors++; $display("FAIL rnd_led[%0d] got %h exp %h", i, led, ref_led);
            end
            checks++;
            if (lat < (hit ? 20 : 11) * BITC - 1 || lat > (hit ? 20 : 11) * BITC + 1) begin
                errors++; $display("FAIL rnd_latency[%0d] got %0d exp %0d", i, lat, (hit ? 20 : 11) * BITC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_read(8'h3C);
        test_busy();
        test_reset_mid();
        test_read(8'h81);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-byte I2C master.
- Takes one transaction command from the system-clock domain and generates START, 7-bit address + R/W, ACK handling, one data byte and STOP on i2c_scl/i2c_sda.
- Sits directly upstream of the LED I2C slave (address 7'b0000010) and drives its SCL/SDA pins.
- Slave samples and updates SDA on SCL falling edges, never stretches SCL.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- I2C_FREQ_HZ, 100_000, SCL frequency.
- QDIV, CLK_FREQ_HZ/(4*I2C_FREQ_HZ), clk cycles per quarter SCL period; must be >= 4.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  command strobe; accepted only when ready=1.
- rw_bit  in  1  0 = write, 1 = read; captured on accept.
- slv_addr  in  7  target address; captured on accept.
- wdata  in  8  write byte; captured on accept.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when STOP completes.
- ack_err  out  1  1 = address or write-data NACK in last transaction.
- rdata  out  8  byte read in last read transaction.
- i2c_scl  out  1  SCL, push-pull.
- i2c_sda  inout  1  SDA, open-drain: drive 0 or release to 'z'.
- mst_state  out  4  current FSM state, debug.

Behaviour:
- Reset values:
  - ready=1, done=0, ack_err=0, rdata=0.
  - i2c_scl=1, SDA released, mst_state=IDLE.
  - Quarter counter, bit counter and shift register cleared.
- Reset mid-transaction: immediate abort to IDLE; SCL=1, SDA released. No STOP generated.
- Bit timing:
  - Quarter tick every QDIV clk cycles.
  - Each bit = 4 quarters: q0 SCL=0, SDA updated at start of q0; q1 SCL=1; q2 SCL=1, SDA sampled at end of q2; q3 SCL=0.
  - SDA never changes while SCL=1, except START/STOP.
- Command accept: start=1 and ready=1 in the same cycle.
  - Latch {slv_addr, rw_bit} into shift_reg[7:0], latch wdata.
  - ack_err cleared. Go to START next cycle.
  - start while ready=0 is ignored, no queuing.
- States and transitions:
  - IDLE: SCL=1, SDA released. On accept -> START.
  - START: q0-q1 SDA=1, SCL=1; q2 SDA=0 with SCL=1 (START condition); q3 SCL=0 -> ADDR.
  - ADDR: 8 bits MSB first from shift_reg, bit_cnt 0..7 -> ADDR_ACK.
  - ADDR_ACK: SDA released; sample SDA at q2.
    - SDA=1 (NACK): ack_err=1 -> STOP.
    - SDA=0, rw=0 -> WDATA.
    - SDA=0, rw=1 -> RDATA.
  - WDATA: 8 bits of latched wdata, MSB first -> WDATA_ACK.
  - WDATA_ACK: sample at q2; NACK sets ack_err=1; always -> STOP.
  - RDATA: SDA released; shift in sampled bit each q2, MSB first. After bit 7, rdata updated -> RDATA_NACK.
  - RDATA_NACK: master releases SDA (NACK, single byte) -> STOP.
  - STOP: q0 SCL=0, SDA=0; q1 SCL=1; q2 SDA released (STOP condition); q3 done=1 for one clk -> IDLE.
- Transaction length in SCL bits: write = 1 START + 9 + 9 + 1 STOP = 20; addr-NACK = 11. done rises (20*4*QDIV) clk after accept (+/-1).
- Arithmetic:
  - Quarter counter width = clog2(QDIV); wraps at QDIV-1.
  - bit_cnt is 3 bits; the 8th bit is detected at bit_cnt==7, then cleared.

Optional Feature:
- Macro I2C_MST_SDA_SYNC_EN.
- Defined: SDA input passes through a 2-flop synchronizer; sampling in ACK/RDATA uses the synchronized value taken at end of q2, giving 2 clk extra input latency. Timing margin is still met because QDIV>=4.
- Not defined: raw i2c_sda is sampled directly at end of q2.
- Ports and state timing are identical either way.

Test Plan:
- Write addr=7'h02, wdata=8'hA5, slave model ACKs both:
  - SDA bit sequence 0000010_0, A,1,0,1,0,0,1,0,1;
  - ack_err=0, done pulses once, slave led=8'hA5.
- Write addr=7'h05: slave NACKs (SDA stays 1) -> ack_err=1, no data byte clocked, STOP follows ADDR_ACK, 11 SCL bits total.
- Read addr=7'h02 after writing 8'h3C -> rdata=8'h3C, master releases SDA in NACK bit, ack_err=0.
- start pulsed while busy (mid-ADDR) -> ignored; ready stays 0; current transfer completes unchanged.
- Assert reset low during WDATA bit 3 -> same cycle: SCL=1, SDA='z', ready=1, mst_state=IDLE; next command completes normally.
- With QDIV=4 and I2C_MST_SDA_SYNC_EN both defined and undefined: rdata=8'h81 read correctly in both builds.
